// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-set input bus and instruction-memory write bus
//
// Purpose: bundles the instruction field-set handshake (producer -> encoder)
//          and the instruction-memory write port (encoder -> memory).
// Parameter: ADDR_W - instruction-memory address width.
// Signals:
//   in_valid / in_ready        field-set handshake
//   in_kind, in_vec, in_alu    instruction class, vector flag, ALU operation
//   in_rs, in_rt, in_rd        register specifiers
//   in_imm                     immediate or branch offset
//   mem_we, mem_addr,
//   mem_wdata                  one-cycle write strobe, address, encoded word
// Modports: slave (the encoder), master (the producer / memory side).

interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic              in_vec;
  logic [2:0]        in_alu;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_kind, in_vec, in_alu, in_rs, in_rt, in_rd, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_kind, in_vec, in_alu, in_rs, in_rt, in_rd, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - instruction field-set encoder and memory loader
//
// Purpose: after a start pulse, accepts instruction field sets, encodes each
//          into a 32-bit word and writes it to consecutive instruction-memory
//          addresses, one word per cycle, until the memory is full.
// Parameter: ADDR_W - address width; memory depth is 2^ADDR_W words.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse starting a load session (IDLE/DONE -> LOAD)
//   bus        instr_encoder_if.slave: field-set handshake + memory write bus
//   busy       high while in LOAD
//   done       high while in DONE
//   err        sticky illegal-field-set flag
//   err_count  illegal field sets seen this session, saturating at 255
// Build option: INSTR_ENCODER_ILLEGAL_CHECK_EN - when defined, illegal field
//   sets are dropped and counted; when undefined they are written as an
//   all-zero word and err/err_count stay 0.

module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter is one bit wider than the address so "memory full" is its MSB.
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   count;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              ready;
  logic              accept;
  logic              legal;
  logic [31:0]       enc;
  logic [31:0]       wdata_next;

  assign ready        = (state == LOAD) && !count[ADDR_W];
  assign accept       = bus.in_valid && ready;
  assign bus.in_ready = ready;

  // A write registered on the cycle before rst is raised is suppressed
  // during the reset cycle itself, so a reset right after an acceptance
  // never reaches the memory.
  assign bus.mem_we    = we_q && !rst;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Field-set decode: legality and the encoded word.
  always_comb begin
    legal = 1'b0;
    enc   = 32'h0000_0000;
    unique case (bus.in_kind)
      2'b00: begin
        legal = (bus.in_alu == 3'b000) || (bus.in_alu == 3'b001) ||
                (bus.in_alu == 3'b010);
        enc   = {(bus.in_vec ? 6'b100000 : 6'b000000),
                 bus.in_rs, bus.in_rt, bus.in_rd, 8'h00, bus.in_alu};
      end
      2'b01: begin
        legal = !bus.in_vec &&
                ((bus.in_alu == 3'b000) || (bus.in_alu == 3'b010));
        enc   = {((bus.in_alu == 3'b010) ? 6'b001010 : 6'b001000),
                 bus.in_rs, bus.in_rt, bus.in_imm};
      end
      2'b10: begin
        legal = !bus.in_vec && (bus.in_alu == 3'b001);
        enc   = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      end
      default: begin
        legal = 1'b0;
        enc   = 32'h0000_0000;
      end
    endcase
    wdata_next = legal ? enc : 32'h0000_0000;
  end

`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
  logic       err_q;
  logic [7:0] err_count_q;

  assign err       = err_q;
  assign err_count = err_count_q;
`else
  assign err       = 1'b0;
  assign err_count = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
`endif
    end else begin
      we_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
            count <= '0;
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
`endif
          end
        end
        LOAD: begin
          // The last write is issued on the cycle count reaches FULL;
          // DONE follows on the next edge.
          if (count == FULL) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (accept) begin
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
            if (legal) begin
              we_q    <= 1'b1;
              addr_q  <= count[ADDR_W-1:0];
              wdata_q <= enc;
              count   <= count + 1'b1;
            end else begin
              err_q <= 1'b1;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end
`else
            we_q    <= 1'b1;
            addr_q  <= count[ADDR_W-1:0];
            wdata_q <= wdata_next;
            count   <= count + 1'b1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder

module tb_instr_encoder;

  logic clk;
  logic rst;
  logic start8;
  logic start2;
  logic busy8, done8, err8;
  logic [7:0] errc8;
  logic busy2, done2, err2;
  logic [7:0] errc2;

  int total;
  int bad;

  instr_encoder_if #(.ADDR_W(8)) b8 ();
  instr_encoder_if #(.ADDR_W(2)) b2 ();

  instr_encoder #(.ADDR_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .bus       (b8),
    .busy      (busy8),
    .done      (done8),
    .err       (err8),
    .err_count (errc8)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .bus       (b2),
    .busy      (busy2),
    .done      (done2),
    .err       (err2),
    .err_count (errc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [1:0] k, input logic v, input logic [2:0] a,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [15:0] im);
    b8.in_valid = 1'b1;
    b8.in_kind  = k;
    b8.in_vec   = v;
    b8.in_alu   = a;
    b8.in_rs    = s;
    b8.in_rt    = t;
    b8.in_rd    = d;
    b8.in_imm   = im;
  endtask

  task automatic drive2(input logic [4:0] i);
    b2.in_valid = 1'b1;
    b2.in_kind  = 2'b00;
    b2.in_vec   = 1'b0;
    b2.in_alu   = 3'b000;
    b2.in_rs    = i;
    b2.in_rt    = 5'd0;
    b2.in_rd    = i;
    b2.in_imm   = 16'h0000;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    drive8(2'b00, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    b8.in_valid = 1'b0;
    drive2(5'd0);
    b2.in_valid = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_we",    b8.mem_we,    0);
    chk("rst_mem_addr",  b8.mem_addr,  0);
    chk("rst_mem_wdata", b8.mem_wdata, 0);
    chk("rst_busy",      busy8,        0);
    chk("rst_done",      done8,        0);
    chk("rst_in_ready",  b8.in_ready,  0);
    chk("rst_err",       err8,         0);
    chk("rst_err_count", errc8,        0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", b8.in_ready, 0);

    // Start a session
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("load_busy",     busy8,       1);
    chk("load_in_ready", b8.in_ready, 1);
    chk("load_done",     done8,       0);

    // Three back-to-back legal words: R-type sub, immediate mul, branch
    drive8(2'b00, 1'b0, 3'b001, 5'd1, 5'd2, 5'd3, 16'h0000);
    tick();
    chk("rtype_we",    b8.mem_we,    1);
    chk("rtype_addr",  b8.mem_addr,  0);
    chk("rtype_wdata", b8.mem_wdata, 32'h0022_1801);
    drive8(2'b01, 1'b0, 3'b010, 5'd4, 5'd5, 5'd0, 16'h00FF);
    tick();
    chk("imm_we",    b8.mem_we,    1);
    chk("imm_addr",  b8.mem_addr,  1);
    chk("imm_wdata", b8.mem_wdata, 32'h2885_00FF);
    drive8(2'b10, 1'b0, 3'b001, 5'd1, 5'd2, 5'd0, 16'hFFFE);
    tick();
    chk("br_we",    b8.mem_we,    1);
    chk("br_addr",  b8.mem_addr,  2);
    chk("br_wdata", b8.mem_wdata, 32'h1022_FFFE);
    b8.in_valid = 1'b0;
    tick();
    chk("hold_we",    b8.mem_we,    0);
    chk("hold_addr",  b8.mem_addr,  2);
    chk("hold_wdata", b8.mem_wdata, 32'h1022_FFFE);

    // Illegal sets: immediate with vec=1, then reserved kind
    drive8(2'b01, 1'b1, 3'b000, 5'd4, 5'd5, 5'd0, 16'h1111);
    tick();
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
    chk("ill1_we",   b8.mem_we,   0);
    chk("ill1_err",  err8,        1);
    chk("ill1_errc", errc8,       1);
    chk("ill1_addr", b8.mem_addr, 2);
`else
    chk("ill1_we",    b8.mem_we,    1);
    chk("ill1_addr",  b8.mem_addr,  3);
    chk("ill1_wdata", b8.mem_wdata, 0);
    chk("ill1_err",   err8,         0);
    chk("ill1_errc",  errc8,        0);
`endif
    drive8(2'b11, 1'b0, 3'b000, 5'd7, 5'd7, 5'd7, 16'h2222);
    tick();
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
    chk("ill2_we",   b8.mem_we, 0);
    chk("ill2_errc", errc8,     2);
`else
    chk("ill2_addr",  b8.mem_addr,  4);
    chk("ill2_wdata", b8.mem_wdata, 0);
`endif
    // Legal vector R-type mul after the illegal sets
    drive8(2'b00, 1'b1, 3'b010, 5'd5, 5'd6, 5'd7, 16'h0000);
    tick();
    chk("vec_we",    b8.mem_we,    1);
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
    chk("vec_addr",  b8.mem_addr,  3);
`else
    chk("vec_addr",  b8.mem_addr,  5);
`endif
    chk("vec_wdata", b8.mem_wdata, 32'h80A6_3802);
    b8.in_valid = 1'b0;

    // start during LOAD must not restart the counter
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("start_ign_busy", busy8, 1);
    drive8(2'b01, 1'b0, 3'b000, 5'd2, 5'd3, 5'd0, 16'h1234);
    tick();
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
    chk("start_ign_addr", b8.mem_addr, 4);
`else
    chk("start_ign_addr", b8.mem_addr, 6);
`endif
    chk("start_ign_wdata", b8.mem_wdata, 32'h2043_1234);

    // Reset on the cycle after an acceptance cancels the write
    drive8(2'b00, 1'b0, 3'b010, 5'd0, 5'd0, 5'd0, 16'h0000);
    tick();
    chk("pre_rst_we", b8.mem_we, 1);
    rst = 1'b1;
    b8.in_valid = 1'b0;
    #1;
    chk("rst_cancel_we", b8.mem_we, 0);
    tick();
    chk("mid_rst_addr",     b8.mem_addr,  0);
    chk("mid_rst_wdata",    b8.mem_wdata, 0);
    chk("mid_rst_busy",     busy8,        0);
    chk("mid_rst_in_ready", b8.in_ready,  0);
    chk("mid_rst_err",      err8,         0);
    rst = 1'b0;
    drive8(2'b00, 1'b0, 3'b000, 5'd1, 5'd1, 5'd1, 16'h0000);
    tick();
    tick();
    chk("post_rst_in_ready", b8.in_ready, 0);
    chk("post_rst_we",       b8.mem_we,   0);
    b8.in_valid = 1'b0;

    // New session restarts at address 0
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    drive8(2'b10, 1'b0, 3'b001, 5'd31, 5'd31, 5'd0, 16'h0001);
    tick();
    chk("restart_addr",  b8.mem_addr,  0);
    chk("restart_wdata", b8.mem_wdata, 32'h13FF_0001);
    b8.in_valid = 1'b0;

    // ADDR_W=2: fill all four words back to back
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("w2_in_ready", b2.in_ready, 1);
    drive2(5'd0);
    tick();
    chk("w2_addr0",  b2.mem_addr,  0);
    chk("w2_data0",  b2.mem_wdata, 32'h0000_0000);
    chk("w2_we0",    b2.mem_we,    1);
    drive2(5'd1);
    tick();
    chk("w2_addr1",  b2.mem_addr,  1);
    chk("w2_data1",  b2.mem_wdata, 32'h0020_0800);
    drive2(5'd2);
    tick();
    chk("w2_addr2",  b2.mem_addr,  2);
    chk("w2_data2",  b2.mem_wdata, 32'h0040_1000);
    drive2(5'd3);
    tick();
    chk("w2_addr3",     b2.mem_addr,  3);
    chk("w2_data3",     b2.mem_wdata, 32'h0060_1800);
    chk("w2_we3",       b2.mem_we,    1);
    chk("w2_full_rdy",  b2.in_ready,  0);
    chk("w2_full_done", done2,        0);
    // in_valid stays high: nothing more may be accepted
    tick();
    chk("w2_done",       done2,        1);
    chk("w2_done_busy",  busy2,        0);
    chk("w2_done_we",    b2.mem_we,    0);
    chk("w2_done_rdy",   b2.in_ready,  0);
    chk("w2_done_addr",  b2.mem_addr,  3);
    b2.in_valid = 1'b0;

    // DONE -> LOAD on start, counter cleared
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("w2_reload_done", done2,       0);
    chk("w2_reload_rdy",  b2.in_ready, 1);
    drive2(5'd1);
    tick();
    chk("w2_reload_addr", b2.mem_addr, 0);
    chk("w2_reload_we",   b2.mem_we,   1);
    b2.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the instruction-memory address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load session.
REQ-005 SHALL have port in_valid, input, 1 bit: an instruction field set is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the encoder accepts a field set this cycle.
REQ-007 SHALL have port in_kind, input, 2 bits: 00 R-type, 01 immediate, 10 branch, 11 reserved.
REQ-008 SHALL have port in_vec, input, 1 bit: vector lane operation.
REQ-009 SHALL have port in_alu, input, 3 bits: ALU operation, where 000 is add, 001 is sub and 010 is mul.
REQ-010 SHALL have ports in_rs, in_rt and in_rd, each input, 5 bits: register specifiers.
REQ-011 SHALL have port in_imm, input, 16 bits: the immediate or branch offset.
REQ-012 SHALL have port mem_we, output, 1 bit: the instruction-memory write strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_W bits: the write address.
REQ-014 SHALL have port mem_wdata, output, 32 bits: the encoded instruction.
REQ-015 SHALL have port busy, output, 1 bit: high while in LOAD.
REQ-016 SHALL have port done, output, 1 bit: high while in DONE.
REQ-017 SHALL have port err, output, 1 bit: sticky flag for an illegal field set.
REQ-018 SHALL have port err_count, output, 8 bits: the number of illegal field sets, saturating at 255.

Function
REQ-019 SHALL implement the states IDLE, LOAD and DONE; start moves IDLE→LOAD or DONE→LOAD; start during LOAD is ignored.
REQ-020 SHALL clear the word counter, err and err_count on entry to LOAD.
REQ-021 SHALL drive in_ready = (state==LOAD) && (accepted count < 2^ADDR_W).
REQ-022 SHALL accept a field set only on a cycle where in_valid && in_ready.
REQ-023 SHALL encode R-type (kind 00) as {opcode, rs, rt, rd, 8'b0, func}, with opcode 000000 (scalar) or 100000 (vector) and func = in_alu; it is legal only for in_alu in {000, 001, 010}.
REQ-024 SHALL encode immediate (kind 01) as {opcode, rs, rt, imm}, legal only with in_vec=0: alu 000 gives opcode 001000 and alu 010 gives opcode 001010.
REQ-025 SHALL encode branch (kind 10) as {000100, rs, rt, imm}, legal only with in_vec=0 and alu 001.
REQ-026 SHALL treat every other combination, including kind 11, as illegal.
REQ-027 SHALL, for an accepted legal set at cycle N, assert mem_we for exactly one cycle at N+1, with mem_addr = the word counter value at acceptance and mem_wdata = the encoding.
REQ-028 SHALL increment the word counter by 1 per legal write; the counter never wraps.
REQ-029 SHALL, after the write to address 2^ADDR_W−1, hold in_ready low and enter DONE on the cycle after that write.
REQ-030 SHALL sustain back-to-back acceptance at one word per cycle, with no bubbles.
REQ-031 SHALL keep mem_addr and mem_wdata at their last values when mem_we=0.

Reset
REQ-032 SHALL, when rst is high, set state=IDLE, counter=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, err_count=0, busy=0, done=0 and in_ready=0 on the next edge.
REQ-033 SHALL, if rst is asserted mid-LOAD, cancel any pending write in the N+1 stage (no mem_we) and require a new start afterwards.
REQ-034 SHALL give rst priority over start in the same cycle.

Configuration
REQ-035 SHALL, with INSTR_ENCODER_ILLEGAL_CHECK_EN defined, drop an illegal set: no write and no counter advance; err is set and err_count increments, saturating at 255.
REQ-036 SHALL, without INSTR_ENCODER_ILLEGAL_CHECK_EN, write an illegal set as 32'h0000_0000 and advance the counter; err and err_count are tied to 0.

Verification
REQ-037 SHALL cover: start, then accept kind 00, vec=0, alu=001, rs=1, rt=2, rd=3 → next cycle mem_we=1, mem_addr=0, mem_wdata=32'h0022_1801.
REQ-038 SHALL cover: kind 01, alu=010, rs=4, rt=5, imm=16'h00FF, accepted as the second word → mem_addr=1, mem_wdata=32'h2885_00FF.
REQ-039 SHALL cover: kind 10, vec=0, alu=001, rs=1, rt=2, imm=16'hFFFE → mem_wdata=32'h1022_FFFE.
REQ-040 SHALL cover: with ADDR_W=2, four back-to-back words → addresses 0..3 on consecutive cycles, in_ready low after the 4th, done=1 one cycle after the last mem_we.
REQ-041 SHALL cover, with the macro defined: kind 01, vec=1 → no mem_we, err=1, err_count=1, and the next legal word is written to the unchanged address.
REQ-042 SHALL cover: rst on the cycle after an acceptance → no mem_we, all outputs at reset values, and in_ready stays 0 until start.
